// File: rtl/simplez_mem_arbiter.sv
// Two-port req/ack arbiter in front of the single-port 512x12 Simplez RAM (port A = CPU, B = loader).
// Define SIMPLEZ_ARB_RR_EN for round-robin tie-breaking; otherwise port A has fixed priority.
module simplez_mem_arbiter #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          a_req,
  input  logic          a_rw,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_rw,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rw,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e        r_state;
  state_e        w_state_d;
  logic          r_owner;   // 0 = port A, 1 = port B
  logic          w_owner_d;
  logic [DW-1:0] r_rdata;
  logic          w_grant_b;
  logic          w_own_rw;

`ifdef SIMPLEZ_ARB_RR_EN
  logic r_last;             // port served most recently, 1 = B
  // On a tie the port that was not served last wins.
  assign w_grant_b = b_req && (!a_req || !r_last);
`else
  assign w_grant_b = b_req && !a_req;
`endif

  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    unique case (r_state)
      StIdle: begin
        if (a_req || b_req) begin
          w_owner_d = w_grant_b;
          w_state_d = StAcc;
        end
      end
      StAcc:   w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_addr = r_owner ? b_addr  : a_addr;
    mem_din  = r_owner ? b_wdata : a_wdata;
    w_own_rw = r_owner ? b_rw    : a_rw;
    // Only ACC may drive a write, so an async reset drops mem_rw back to read at once.
    mem_rw   = (r_state == StAcc) ? w_own_rw : 1'b1;
    a_ack    = (r_state == StDone) && !r_owner;
    b_ack    = (r_state == StDone) &&  r_owner;
    rdata    = (r_state == StDone) ? mem_dout : r_rdata;
    busy     = (r_state != StIdle);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_owner <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_d;
      r_owner <= w_owner_d;
      if (r_state == StDone) begin
        r_rdata <= mem_dout;
      end
    end
  end

`ifdef SIMPLEZ_ARB_RR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= 1'b1;
    end else if (r_state == StDone) begin
      r_last <= r_owner;
    end
  end
`endif

endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// Randomised and directed bench for simplez_mem_arbiter with a synchronous-read RAM model
// and a transaction-level reference model (memory image + grant order).
module tb_simplez_mem_arbiter;

`ifdef SIMPLEZ_ARB_RR_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        a_req = 1'b0, a_rw = 1'b1, b_req = 1'b0, b_rw = 1'b1;
  logic [8:0]  a_addr = '0, b_addr = '0;
  logic [11:0] a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, busy, mem_rw;
  logic [11:0] rdata, mem_din;
  logic [11:0] mem_dout = '0;
  logic [8:0]  mem_addr;

  logic [11:0] ram [512];
  logic        ld_en = 1'b0;
  logic [8:0]  ld_addr = '0;
  logic [11:0] ld_data = '0;

  logic [11:0] ref_mem [512];
  logic        model_last;    // last served port, 1 = B
  int          vectors = 0;
  int          miscompares = 0;

  simplez_mem_arbiter #(.AW(9), .DW(12)) dut (
    .clk(clk), .rstn(rstn),
    .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
    .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
    .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_rw(mem_rw),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // genram: write on rw=0, registered read.
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (!mem_rw) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve the requests set up on A and/or B; checks grant order, latency, read data.
  task automatic serve(input logic use_a, input logic use_b);
    logic pa, pb, exp_b, rw, first, rd_seen;
    logic [8:0]  addr;
    logic [11:0] rd_val;
    int n, last_n;
    pa = use_a; pb = use_b; first = 1'b1; rd_seen = 1'b0; rd_val = '0;
    n = 0; last_n = 0;
    a_req = use_a; b_req = use_b;
    while ((pa || pb) && n < 20) begin
      tick(); n++;
      if (a_ack || b_ack) begin
        if (pa && pb) exp_b = Rr ? !model_last : 1'b0;
        else          exp_b = pb;
        chk("ack_a", 32'(a_ack), 32'(!exp_b));
        chk("ack_b", 32'(b_ack), 32'(exp_b));
        chk("ack_latency", n - last_n, first ? 2 : 3);
        rw   = exp_b ? b_rw : a_rw;
        addr = exp_b ? b_addr : a_addr;
        if (rw) begin
          chk("rdata", 32'(rdata), 32'(ref_mem[addr]));
          rd_seen = 1'b1; rd_val = ref_mem[addr];
        end else begin
          ref_mem[addr] = exp_b ? b_wdata : a_wdata;
          rd_seen = 1'b0;
        end
        model_last = exp_b;
        if (exp_b) begin pb = 1'b0; b_req = 1'b0; end
        else       begin pa = 1'b0; a_req = 1'b0; end
        last_n = n; first = 1'b0;
      end
    end
    if (pa || pb) chk("ack_timeout", 32'(pa || pb), 0);
    a_req = 1'b0; b_req = 1'b0;
    tick();
    chk("ack_pulse", 32'({a_ack, b_ack}), 0);
    if (rd_seen) chk("rdata_hold", 32'(rdata), 32'(rd_val));
  endtask

  initial begin
    int n, last_n, cnt;
    logic exp_b;

    // Reset state without any clock edge
    rstn = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_rw", 32'(mem_rw), 1);
    chk("rst_acks", 32'({a_ack, b_ack}), 0);
    chk("rst_rdata", 32'(rdata), 0);

    ld_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      ld_addr = 9'(i);
      ld_data = (i == 0) ? 12'hFFF : 12'($urandom);
      ref_mem[i] = ld_data;
      tick();
    end
    ld_en = 1'b0;
    rstn = 1'b1;
    model_last = 1'b1;
    tick();

    // 1: reset in the ACC cycle of a B write aborts it
    b_rw = 1'b0; b_addr = 9'h010; b_wdata = ~ref_mem[9'h010]; b_req = 1'b1;
    tick();
    chk("t1_acc_busy", 32'(busy), 1);
    chk("t1_acc_rw", 32'(mem_rw), 0);
    #2 rstn = 1'b0;
    #1;
    chk("t1_rst_rw", 32'(mem_rw), 1);
    chk("t1_rst_busy", 32'(busy), 0);
    b_req = 1'b0;
    tick(); tick();
    chk("t1_b_ack", 32'(b_ack), 0);
    chk("t1_ram", 32'(ram[9'h010]), 32'(ref_mem[9'h010]));
    chk("t1_rdata", 32'(rdata), 0);
    rstn = 1'b1;
    model_last = 1'b1;
    tick();

    // 2: A write then read at top address
    a_rw = 1'b0; a_addr = 9'h1FF; a_wdata = 12'h0A5;
    serve(1'b1, 1'b0);
    a_rw = 1'b1;
    serve(1'b1, 1'b0);
    chk("t2_ram", 32'(ram[9'h1FF]), 32'h0A5);

    // 3: B read of address 0
    b_rw = 1'b1; b_addr = 9'h000;
    serve(1'b0, 1'b1);
    chk("t3_rdata", 32'(ref_mem[0]), 32'hFFF);

    // 4: both held for four transfers
    a_rw = 1'b1; a_addr = 9'h021; b_rw = 1'b1; b_addr = 9'h142;
    a_req = 1'b1; b_req = 1'b1;
    n = 0; last_n = 0; cnt = 0;
    while (cnt < 4 && n < 30) begin
      tick(); n++;
      if (a_ack || b_ack) begin
        exp_b = Rr ? !model_last : 1'b0;
        chk("t4_ack_a", 32'(a_ack), 32'(!exp_b));
        chk("t4_ack_b", 32'(b_ack), 32'(exp_b));
        chk("t4_gap", n - last_n, (cnt == 0) ? 2 : 3);
        chk("t4_rdata", 32'(rdata), 32'(ref_mem[exp_b ? b_addr : a_addr]));
        model_last = exp_b;
        last_n = n; cnt++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("t4_count", cnt, 4);
    tick();

    // 5: B request arriving during A's ACC waits for the next IDLE
    a_rw = 1'b1; a_addr = 9'h0C3; b_rw = 1'b0; b_addr = 9'h0C3; b_wdata = 12'h5A5;
    a_req = 1'b1;
    tick();
    b_req = 1'b1;
    tick();
    chk("t5_a_ack", 32'(a_ack), 1);
    chk("t5_b_early", 32'(b_ack), 0);
    chk("t5_a_rdata", 32'(rdata), 32'(ref_mem[9'h0C3]));
    a_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t5_b_ack", 32'(b_ack), 32'(k == 3));
    end
    ref_mem[9'h0C3] = 12'h5A5;
    model_last = 1'b1;
    b_req = 1'b0;
    tick();

    // 6: quiet idle
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t6_idle", 32'({busy, mem_rw, a_ack, b_ack}), 32'b0100);
    end

    // Random traffic, small address pool mixed in to force same-address collisions
    for (int it = 0; it < 60; it++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      a_rw = 1'($urandom); b_rw = 1'($urandom);
      a_addr = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 3)) : 9'($urandom);
      b_addr = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 3)) : 9'($urandom);
      a_wdata = 12'($urandom); b_wdata = 12'($urandom);
      serve(sel != 1, sel != 0);
    end
    for (int i = 0; i < 4; i++) chk("final_ram", 32'(ram[i]), 32'(ref_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
